mul_div_unit: RTL and testbench

//  Iterative signed 32x32 multiply / 32/32 divide engine beside the ALU. Operands come from the

---
 rtl/mul_div_unit_pkg.sv | 16 +
 rtl/mul_div_unit_add_sub_33.sv | 17 +
 rtl/mul_div_unit.sv | 176 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared constants and FSM encoding for the iterative
// multiply / divide engine.
package mul_div_unit_pkg;

   localparam int         MDU_WIDTH  = 32;
   localparam logic [4:0] MDU_OP_MUL = 5'd15;
   localparam logic [4:0] MDU_OP_DIV = 5'd16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mul_div_unit_add_sub_33.sv
// Single carry chain shared by the Booth step, the
// non-restoring step and the remainder restore.
module add_sub_33 #(
   parameter int W = 33
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_sub,
   output logic [W-1:0] o_sum
);

   logic [W-1:0] w_b;

   assign w_b   = i_b ^ {W{i_sub}};
   assign o_sum = i_a + w_b + {{(W-1){1'b0}}, i_sub};

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide
// (non-restoring with sign fix-up), 34-edge fixed latency.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int         WIDTH  = MDU_WIDTH,
   parameter logic [4:0] OP_MUL = MDU_OP_MUL,
   parameter logic [4:0] OP_DIV = MDU_OP_DIV
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             start,
   input  logic [4:0]       opcode,
   input  logic [WIDTH-1:0] input_a,
   input  logic [WIDTH-1:0] input_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   state_t r_state;
   state_t w_state_nx;

   logic [CW-1:0]    r_cnt;
   logic [WIDTH:0]   r_acc;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_m;
   logic             r_qm1;
   logic             r_ph;
   logic             r_is_div;
   logic             r_dz;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_busy;
   logic             r_dbz;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic             w_valid_op;
   logic             w_accept;
   logic             w_is_div;
   logic             w_zero;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH:0]   w_add_a;
   logic [WIDTH:0]   w_add_b;
   logic [WIDTH:0]   w_sum;
   logic             w_sub;

   assign w_valid_op = (opcode == OP_MUL) || (opcode == OP_DIV);
   assign w_accept   = start && w_valid_op &&
                       ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_is_div   = (opcode == OP_DIV);
   assign w_zero     = (input_b == '0);
   assign w_abs_a    = input_a[WIDTH-1] ? -input_a : input_a;
   assign w_abs_b    = input_b[WIDTH-1] ? -input_b : input_b;

   assign busy        = r_busy;
   assign done        = (r_state == S_DONE);
   assign div_by_zero = r_dbz;
   assign hi          = r_hi;
   assign lo          = r_lo;

   add_sub_33 #(.W(WIDTH + 1)) u_add (
      .i_a   (w_add_a),
      .i_b   (w_add_b),
      .i_sub (w_sub),
      .o_sum (w_sum)
   );

   // State register.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) r_state <= S_IDLE;
      else          r_state <= w_state_nx;
   end

   // Next state: divide-by-zero skips straight to the output phase of FIX.
   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (r_state == S_DONE) w_state_nx = S_IDLE;
            if (w_accept)
               w_state_nx = (w_is_div && w_zero) ? S_FIX : S_RUN;
         end
         S_RUN:   if (r_cnt == '0) w_state_nx = S_FIX;
         S_FIX:   if (r_ph) w_state_nx = S_DONE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Adder operand steering for Booth, non-restoring and restore steps.
   always_comb begin
      w_add_a = '0;
      w_add_b = '0;
      w_sub   = 1'b0;
      if ((r_state == S_RUN) && !r_is_div) begin
         w_add_a = {r_acc[WIDTH-1], r_acc[WIDTH-1:0]};
         w_add_b = (r_q[0] ^ r_qm1) ? {r_m[WIDTH-1], r_m} : '0;
         w_sub   = r_q[0] & ~r_qm1;
      end else if (r_state == S_RUN) begin
         w_add_a = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
         w_add_b = {1'b0, r_m};
         w_sub   = ~r_acc[WIDTH];
      end else if ((r_state == S_FIX) && !r_ph) begin
         w_add_a = r_acc;
         w_add_b = r_acc[WIDTH] ? {1'b0, r_m} : '0;
      end
   end

   // Datapath: operand latch, iteration, fix-up and result publish.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_q      <= '0;
         r_m      <= '0;
         r_qm1    <= 1'b0;
         r_ph     <= 1'b0;
         r_is_div <= 1'b0;
         r_dz     <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_busy   <= 1'b0;
         r_dbz    <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else if (w_accept) begin
         r_is_div <= w_is_div;
         r_dz     <= w_is_div && w_zero;
         r_ph     <= w_is_div && w_zero;
         r_neg_q  <= input_a[WIDTH-1] ^ input_b[WIDTH-1];
         r_neg_r  <= input_a[WIDTH-1];
         r_cnt    <= CW'(WIDTH - 1);
         r_acc    <= '0;
         r_qm1    <= 1'b0;
         r_m      <= (w_is_div && !w_zero) ? w_abs_b : input_a;
         r_q      <= w_is_div ? w_abs_a : input_b;
         r_dbz    <= 1'b0;
         r_busy   <= 1'b0;
      end else if (r_state == S_RUN) begin
         r_busy <= 1'b1;
         r_cnt  <= r_cnt - CW'(1);
         if (r_is_div) begin
            r_acc <= w_sum;
            r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
         end else begin
            r_acc <= {w_sum[WIDTH], w_sum[WIDTH:1]};
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            r_qm1 <= r_q[0];
         end
      end else if ((r_state == S_FIX) && !r_ph) begin
         r_ph <= 1'b1;
         if (r_is_div) r_acc <= w_sum;
      end else if (r_state == S_FIX) begin
         r_ph   <= 1'b0;
         r_busy <= 1'b0;
         if (r_dz) begin
            r_hi  <= r_m;
            r_lo  <= '1;
            r_dbz <= 1'b1;
         end else if (r_is_div) begin
            r_hi <= r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            r_lo <= r_neg_q ? -r_q : r_q;
         end else begin
            r_hi <= r_acc[WIDTH-1:0];
            r_lo <= r_q;
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with an expected-result
// queue filled at issue time and drained on done.
module tb_mul_div_unit;

   localparam logic [4:0] OP_MUL = 5'd15;
   localparam logic [4:0] OP_DIV = 5'd16;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
      int          nbusy;
   } exp_t;

   logic        clock = 1'b0;
   logic        clear_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  opcode = '0;
   logic [31:0] input_a = '0;
   logic [31:0] input_b = '0;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_err = 0;
   int          lat;
   int          nb;
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;

   mul_div_unit dut (
      .clock       (clock),
      .clear_n     (clear_n),
      .start       (start),
      .opcode      (opcode),
      .input_a     (input_a),
      .input_b     (input_b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clock = ~clock;

   function automatic exp_t model(input logic [4:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t e;
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] p;
      logic signed [31:0] a32;
      logic signed [31:0] b32;
      e.dz    = 1'b0;
      e.lat   = 34;
      e.nbusy = 33;
      a32 = a;
      b32 = b;
      if (op == OP_MUL) begin
         sa = a32;
         sb = b32;
         p  = sa * sb;
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (b == 32'h0) begin
         e.hi    = a;
         e.lo    = 32'hFFFF_FFFF;
         e.dz    = 1'b1;
         e.lat   = 1;
         e.nbusy = 0;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.hi = 32'h0;
         e.lo = 32'h8000_0000;
      end else begin
         e.lo = a32 / b32;
         e.hi = a32 % b32;
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic issue(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit push);
      if (push) exp_q.push_back(model(op, a, b));
      start   = 1'b1;
      opcode  = op;
      input_a = a;
      input_b = b;
      @(posedge clock);
      @(negedge clock);
      start   = 1'b0;
      input_a = $urandom;
      input_b = $urandom;
   endtask

   task automatic wait_done(input int poke);
      lat = 0;
      nb  = 0;
      while (lat < 40) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
         if (busy) nb++;
         if (done) break;
         if (poke != 0) begin
            if (lat == poke - 1) begin
               start   = 1'b1;
               opcode  = OP_DIV;
               input_a = 32'd9;
               input_b = 32'd0;
            end else begin
               start = 1'b0;
            end
         end
      end
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue"}, 64'd0, 64'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
         chk({tag, "_busy"}, 64'(nb), 64'(e.nbusy));
         chk({tag, "_hilo"}, {hi, lo}, {e.hi, e.lo});
         chk({tag, "_dz"}, 64'(div_by_zero), 64'(e.dz));
         last_hi = e.hi;
         last_lo = e.lo;
      end
   endtask

   initial begin
      clear_n = 1'b0;
      repeat (2) @(posedge clock);
      #2;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dz", 64'(div_by_zero), 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      #2 clear_n = 1'b1;
      @(negedge clock);

      issue(OP_MUL, 32'd2, 32'd3, 1'b1);
      wait_done(0);
      check_result("mul_2x3");
      chk("mul_2x3_lo", 64'(lo), 64'd6);

      issue(OP_MUL, -32'sd7, 32'd12, 1'b1);
      wait_done(0);
      check_result("mul_neg");
      chk("mul_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFAC);

      issue(OP_MUL, 32'h8000_0000, 32'h8000_0000, 1'b1);
      wait_done(0);
      check_result("mul_min");
      chk("mul_min_const", {hi, lo}, 64'h4000_0000_0000_0000);

      issue(OP_DIV, 32'd17, 32'd3, 1'b1);
      wait_done(0);
      check_result("div_pp");

      issue(OP_DIV, -32'sd17, 32'd3, 1'b1);
      wait_done(0);
      check_result("div_np");
      chk("div_np_const", {hi, lo}, {32'hFFFF_FFFE, 32'hFFFF_FFFB});

      issue(OP_DIV, 32'd17, -32'sd3, 1'b1);
      wait_done(0);
      check_result("div_pn");

      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_done(0);
      check_result("div_ovf");

      issue(OP_DIV, 32'd20, 32'd0, 1'b1);
      wait_done(0);
      check_result("div_zero");

      issue(OP_MUL, 32'd1000, -32'sd3, 1'b1);
      chk("dz_clear", 64'(div_by_zero), 64'd0);
      wait_done(10);
      check_result("mul_poke");

      start   = 1'b1;
      opcode  = 5'd3;
      input_a = 32'd55;
      input_b = 32'd66;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      chk("badop_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clock);
      chk("badop_done", 64'(done), 64'd0);
      chk("badop_hilo", {hi, lo}, {last_hi, last_lo});

      issue(OP_DIV, -32'sd100, 32'd7, 1'b1);
      wait_done(0);
      check_result("b2b_first");
      issue(OP_MUL, 32'd123456, -32'sd789, 1'b1);
      wait_done(0);
      check_result("b2b_second");

      issue(OP_DIV, 32'd100, 32'd7, 1'b0);
      repeat (14) @(posedge clock);
      #2 clear_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_hilo", {hi, lo}, 64'd0);
      #3 clear_n = 1'b1;
      @(negedge clock);

      issue(OP_MUL, 32'd12, 32'd17, 1'b1);
      wait_done(0);
      check_result("mul_after_rst");
      chk("mul_after_rst_lo", 64'(lo), 64'd204);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
